// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and the per-transfer mode bundle.
package spi_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: half-period tick counter, leading/trailing edge strobes and the registered sclk.
module spi_clk_gen #(
  parameter int HALF_PERIOD = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic edge_en,
  input  logic cpol,
  output logic tick,
  output logic lead_edge,
  output logic trail_edge,
  output logic sclk
);

  localparam int HW = $clog2(HALF_PERIOD);
  localparam logic [HW-1:0] CNT_MAX = HW'(HALF_PERIOD - 1);

  logic [HW-1:0] cnt_r;
  logic          sclk_r;

  // Half-period counter, parked at zero while disabled so a new transfer starts aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {HW{1'b0}};
    end else if (!en) begin
      cnt_r <= {HW{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      cnt_r <= {HW{1'b0}};
    end else begin
      cnt_r <= cnt_r + HW'(1);
    end
  end

  // Edge strobes; a leading edge is the one that moves sclk away from its idle level.
  always_comb begin
    tick       = en && (cnt_r == CNT_MAX);
    lead_edge  = tick && edge_en && (sclk_r == cpol);
    trail_edge = tick && edge_en && (sclk_r != cpol);
  end

  // sclk follows the idle polarity while disabled and toggles on each strobe otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_r <= 1'b0;
    end else if (!en) begin
      sclk_r <= cpol;
    end else if (lead_edge || trail_edge) begin
      sclk_r <= ~sclk_r;
    end else begin
      sclk_r <= sclk_r;
    end
  end

  assign sclk = sclk_r;

endmodule

// File: rtl/spi_master_multi.sv
// Multi-slave SPI master: FSM, shift registers and chip-select decode around spi_clk_gen.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter  int DATA_W      = 8,
  parameter  int NUM_CS      = 3,
  parameter  int HALF_PERIOD = 10,
  localparam int CS_W        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              mosi,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W);
  localparam logic [EW-1:0] EDGE_PRE  = EW'(2 * DATA_W - 1);

  logic [1:0]        state_r;
  spi_mode_t         mode_r;
  logic [DATA_W-1:0] tx_sh_r;
  logic [DATA_W-1:0] rx_sh_r;
  logic [DATA_W-1:0] rx_data_r;
  logic [EW-1:0]     edge_cnt_r;
  logic [NUM_CS-1:0] cs_n_r;
  logic              mosi_r;
  logic              done_r;

  logic              accept_s;
  logic              clk_en_s;
  logic              edge_en_s;
  logic              cpol_s;
  logic              tick_s;
  logic              lead_s;
  logic              trail_s;
  logic              drive_s;
  logic              sample_s;
  logic [DATA_W-1:0] tx_ord_s;
  logic [NUM_CS-1:0] cs_dec_s;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = {DATA_W{1'b0}};
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  // Out-of-range indices decode to no select at all (dummy clocks).
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] r;
    r = {NUM_CS{1'b1}};
    for (int i = 0; i < NUM_CS; i++) r[i] = (sel != CS_W'(i));
    return r;
  endfunction

  // Handshake, edge gating and per-mode drive/sample selection.
  always_comb begin
    accept_s  = start && (state_r == ST_IDLE);
    clk_en_s  = (state_r != ST_IDLE);
    edge_en_s = (state_r == ST_SETUP) || ((state_r == ST_SHIFT) && (edge_cnt_r != EDGE_LAST));
    cpol_s    = accept_s ? cpol : mode_r.cpol;
    tx_ord_s  = lsb_first ? bit_rev(tx_data) : tx_data;
    cs_dec_s  = cs_decode(cs_sel);
    if (mode_r.cpha) begin
      drive_s  = lead_s;
      sample_s = trail_s;
    end else begin
      drive_s  = trail_s && (edge_cnt_r != EDGE_PRE);
      sample_s = lead_s;
    end
  end

  spi_clk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (clk_en_s),
    .edge_en   (edge_en_s),
    .cpol      (cpol_s),
    .tick      (tick_s),
    .lead_edge (lead_s),
    .trail_edge(trail_s),
    .sclk      (sclk)
  );

  // Transfer FSM with the shift datapath; SHIFT keeps one quiet half-period after the last edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      mode_r     <= spi_mode_t'(3'b000);
      tx_sh_r    <= {DATA_W{1'b0}};
      rx_sh_r    <= {DATA_W{1'b0}};
      rx_data_r  <= {DATA_W{1'b0}};
      edge_cnt_r <= {EW{1'b0}};
      cs_n_r     <= {NUM_CS{1'b1}};
      mosi_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (sample_s) rx_sh_r <= {rx_sh_r[DATA_W-2:0], miso};
      if (lead_s || trail_s) edge_cnt_r <= edge_cnt_r + EW'(1);
      if (drive_s) begin
        mosi_r  <= tx_sh_r[DATA_W-1];
        tx_sh_r <= {tx_sh_r[DATA_W-2:0], 1'b0};
      end
      case (state_r)
        ST_IDLE: begin
          mosi_r <= 1'b0;
          if (accept_s) begin
            state_r    <= ST_SETUP;
            mode_r     <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
            cs_n_r     <= cs_dec_s;
            edge_cnt_r <= {EW{1'b0}};
            rx_sh_r    <= {DATA_W{1'b0}};
            if (!cpha) begin
              mosi_r  <= tx_ord_s[DATA_W-1];
              tx_sh_r <= {tx_ord_s[DATA_W-2:0], 1'b0};
            end else begin
              tx_sh_r <= tx_ord_s;
            end
          end
        end
        ST_SETUP: begin
          if (tick_s) state_r <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick_s && (edge_cnt_r == EDGE_LAST)) state_r <= ST_HOLD;
        end
        ST_HOLD: begin
          if (tick_s) begin
            state_r   <= ST_IDLE;
            cs_n_r    <= {NUM_CS{1'b1}};
            mosi_r    <= 1'b0;
            done_r    <= 1'b1;
            rx_data_r <= mode_r.lsb_first ? bit_rev(rx_sh_r) : rx_sh_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cs_n_r  <= {NUM_CS{1'b1}};
          mosi_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = (state_r == ST_IDLE);
  assign busy    = ~ready;
  assign done    = done_r;
  assign rx_data = rx_data_r;
  assign mosi    = mosi_r;
  assign cs_n    = cs_n_r;

endmodule
